// File: rtl/ahb_lite_master_arbiter.sv
// ahb_lite_master_arbiter
//   Shares one AHB-Lite slave-side bus between two masters: master 0 is the
//   data adapter and master 1 is the instruction adapter. The granted master
//   drives the address phase. The previous owner drives the data phase. Each
//   master's hready is gated so that a master without the grant never sees
//   its transfer accepted. Per-master accepted-transfer counters are kept for
//   performance monitoring.
//
// Parameters
//   RR_EN  1: round-robin on contention, 0: fixed priority (master 0 first)
//   CNT_W  width of the transfer counters
//
// Ports
//   hclk_i, hreset_i             clock, async active-high reset
//   mN_h*_i                      master N request, address phase and wdata
//   mN_hgrant_o                  master N owns the address phase
//   mN_hready_o                  hready gated by ownership
//   mN_hrdata_o, mN_hresp_o      broadcast read data and response
//   h*_o (address phase)         slave-side address phase from the owner
//   hwdata_o                     slave-side write data from the data-phase owner
//   hready_i, hrdata_i, hresp_i  slave-side response
//   hmaster_o                    current address-phase owner
//   cnt_clr_i                    synchronous clear of both counters
//   mN_xfer_cnt_o                saturating accepted-transfer counters
//
// Owner FSM
//   state   | meaning
//   OWN_M0  | master 0 owns the address phase (reset / parked default)
//   OWN_M1  | master 1 owns the address phase
module ahb_lite_master_arbiter #(
  parameter int RR_EN = 1,
  parameter int CNT_W = 16
) (
  input  logic             hclk_i,
  input  logic             hreset_i,
  input  logic             m0_hbusreq_i,
  input  logic [31:0]      m0_haddr_i,
  input  logic [1:0]       m0_htrans_i,
  input  logic             m0_hwrite_i,
  input  logic [2:0]       m0_hsize_i,
  input  logic [2:0]       m0_hburst_i,
  input  logic [3:0]       m0_hprot_i,
  input  logic             m0_hmastlock_i,
  input  logic [31:0]      m0_hwdata_i,
  output logic             m0_hgrant_o,
  output logic             m0_hready_o,
  output logic [31:0]      m0_hrdata_o,
  output logic             m0_hresp_o,
  input  logic             m1_hbusreq_i,
  input  logic [31:0]      m1_haddr_i,
  input  logic [1:0]       m1_htrans_i,
  input  logic             m1_hwrite_i,
  input  logic [2:0]       m1_hsize_i,
  input  logic [2:0]       m1_hburst_i,
  input  logic [3:0]       m1_hprot_i,
  input  logic             m1_hmastlock_i,
  input  logic [31:0]      m1_hwdata_i,
  output logic             m1_hgrant_o,
  output logic             m1_hready_o,
  output logic [31:0]      m1_hrdata_o,
  output logic             m1_hresp_o,
  output logic [31:0]      haddr_o,
  output logic [1:0]       htrans_o,
  output logic             hwrite_o,
  output logic [2:0]       hsize_o,
  output logic [2:0]       hburst_o,
  output logic [3:0]       hprot_o,
  output logic             hmastlock_o,
  output logic [31:0]      hwdata_o,
  input  logic             hready_i,
  input  logic [31:0]      hrdata_i,
  input  logic             hresp_i,
  output logic             hmaster_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] m0_xfer_cnt_o,
  output logic [CNT_W-1:0] m1_xfer_cnt_o
);

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  owner_t           r_owner;
  owner_t           r_dp_owner;
  owner_t           r_last;
  owner_t           w_owner_nxt;
  owner_t           w_last_nxt;
  logic             w_handover;
  logic             w_xfer;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Owner, data-phase owner and round-robin history. All three freeze
  // while the slave inserts wait states.
  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      r_owner    <= OWN_M0;
      r_dp_owner <= OWN_M0;
      r_last     <= OWN_M1;
    end else if (hready_i) begin
      r_owner    <= w_owner_nxt;
      r_dp_owner <= r_owner;
      r_last     <= w_last_nxt;
    end
  end

  always_comb begin
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    // Handover only when the owner leaves nothing outstanding after this
    // edge: no NONSEQ/SEQ being accepted and no locked sequence.
    w_handover  = hready_i & ~htrans_o[1] & ~hmastlock_o;
    if (w_handover) begin
      unique case ({m1_hbusreq_i, m0_hbusreq_i})
        2'b01: w_owner_nxt = OWN_M0;
        2'b10: w_owner_nxt = OWN_M1;
        2'b11: begin
          if (RR_EN != 0) begin
            w_owner_nxt = (r_last == OWN_M0) ? OWN_M1 : OWN_M0;
            w_last_nxt  = w_owner_nxt;
          end else begin
            w_owner_nxt = OWN_M0;
          end
        end
        default: w_owner_nxt = r_owner;  // no request: park on current owner
      endcase
    end
  end

  always_comb begin
    hmaster_o   = r_owner;
    m0_hgrant_o = (r_owner == OWN_M0);
    m1_hgrant_o = (r_owner == OWN_M1);
    m0_hready_o = hready_i & (r_owner == OWN_M0);
    m1_hready_o = hready_i & (r_owner == OWN_M1);
    m0_hrdata_o = hrdata_i;
    m1_hrdata_o = hrdata_i;
    m0_hresp_o  = hresp_i;
    m1_hresp_o  = hresp_i;
    if (r_owner == OWN_M1) begin
      haddr_o     = m1_haddr_i;
      htrans_o    = m1_htrans_i;
      hwrite_o    = m1_hwrite_i;
      hsize_o     = m1_hsize_i;
      hburst_o    = m1_hburst_i;
      hprot_o     = m1_hprot_i;
      hmastlock_o = m1_hmastlock_i;
    end else begin
      haddr_o     = m0_haddr_i;
      htrans_o    = m0_htrans_i;
      hwrite_o    = m0_hwrite_i;
      hsize_o     = m0_hsize_i;
      hburst_o    = m0_hburst_i;
      hprot_o     = m0_hprot_i;
      hmastlock_o = m0_hmastlock_i;
    end
    hwdata_o = (r_dp_owner == OWN_M1) ? m1_hwdata_i : m0_hwdata_i;
  end

  // A transfer is accepted on an edge where the owner presents NONSEQ/SEQ
  // and the slave is ready.
  assign w_xfer = hready_i & htrans_o[1];

  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (cnt_clr_i) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_xfer) begin
      if (r_owner == OWN_M0) begin
        if (r_cnt0 != CNT_MAX) r_cnt0 <= r_cnt0 + CNT_ONE;
      end else begin
        if (r_cnt1 != CNT_MAX) r_cnt1 <= r_cnt1 + CNT_ONE;
      end
    end
  end

  assign m0_xfer_cnt_o = r_cnt0;
  assign m1_xfer_cnt_o = r_cnt1;

endmodule

// File: doc/ahb_lite_master_arbiter.md
# ahb_lite_master_arbiter

- Two-master AHB-Lite arbiter that shares one AHB-Lite slave-side bus between the core's OBI-to-AHB data adapter (master 0) and instruction adapter (master 1).
- Routes the address phase of the granted master and the data phase of the previous owner to the bus.
- Gates each master's `hready` so that a master without the grant can never see its request accepted.
- Keeps per-master accepted-transfer counters for performance monitoring.

## Interface
Parameters:
- `RR_EN`, default 1: 1 selects round-robin on contention; 0 selects fixed priority with master 0 first.
- `CNT_W`, default 16: width of the transfer counters.

Ports (`mN_` is a per-master group, N = 0 data, N = 1 instruction):
- `hclk_i` input 1: single clock.
- `hreset_i` input 1: asynchronous, active-high reset.
- `mN_hbusreq_i` input 1: bus request from master N.
- `mN_haddr_i` input 32: master N address.
- `mN_htrans_i` input 2: master N transfer type.
- `mN_hwrite_i` input 1: master N transfer direction.
- `mN_hsize_i` input 3: master N transfer size.
- `mN_hburst_i` input 3: master N burst type.
- `mN_hprot_i` input 4: master N protection control.
- `mN_hmastlock_i` input 1: master N locked-sequence indicator.
- `mN_hwdata_i` input 32: master N write data.
- `mN_hgrant_o` output 1: master N owns the address phase.
- `mN_hready_o` output 1: gated `hready` to master N.
- `mN_hrdata_o` output 32: read data to master N.
- `mN_hresp_o` output 1: transfer response to master N.
- `haddr_o`, `htrans_o`, `hwrite_o`, `hsize_o`, `hburst_o`, `hprot_o`, `hmastlock_o` outputs 32/2/1/3/3/4/1: slave-side address-phase signals.
- `hwdata_o` output 32: slave-side write data.
- `hready_i` input 1: slave-side ready.
- `hrdata_i` input 32: slave-side read data.
- `hresp_i` input 1: slave-side response.
- `hmaster_o` output 1: index of the current address-phase owner.
- `cnt_clr_i` input 1: synchronous clear of both transfer counters.
- `m0_xfer_cnt_o`, `m1_xfer_cnt_o` outputs `CNT_W`: accepted-transfer counters.

## Operation
- **State:**
  - `owner` (1 bit): address-phase owner; drives `hmaster_o` and `mN_hgrant_o` (one-hot).
  - `dp_owner` (1 bit): data-phase owner.
  - `last` (1 bit): last master granted on contention.
- **Address mux:** all slave-side address-phase outputs are combinationally taken from `owner`'s inputs.
- **Data mux:** `hwdata_o` is taken from `dp_owner`'s `hwdata_i`.
- **Response routing:** `hrdata_i` and `hresp_i` are broadcast to both masters.
- **Ready gating:** `mN_hready_o = hready_i & (owner == N)`. A non-owner sees 0, so an adapter's `gnt` cannot fire.
- **Handover condition:** `hready_i`=1, owner's `htrans[1]`=0 (IDLE/BUSY), and owner's `hmastlock_i`=0.
  - This guarantees the old owner has no data phase outstanding after the edge.
- **Next-owner selection at a handover edge:**
  - Only one master requesting: that master.
  - Both requesting with `RR_EN`=1: the master not equal to `last`. Then set `last` to the chosen master.
  - Both requesting with `RR_EN`=0: master 0.
  - No request: `owner` holds (bus parking).
- **No preemption:** an owner issuing back-to-back NONSEQ with `hbusreq` high keeps the bus.
- **Data-phase owner update:** `dp_owner <= owner` on every edge with `hready_i`=1.
- **Counters:** `mN_xfer_cnt` increments on an edge with `hready_i`=1, `owner`==N and `htrans_o[1]`=1.
  - Saturates at all-ones.
  - `cnt_clr_i` has priority over increment.

## Timing
- **Reset values:** `owner`=0, `dp_owner`=0, `last`=1.
  - Counters 0.
  - `m0_hgrant_o`=1, `m1_hgrant_o`=0, `hmaster_o`=0.
  - Slave-side outputs follow master 0's inputs (combinational).
- **Arbitration latency:** request in cycle N with the handover condition true → new owner's grant and `hready_o` are valid in cycle N+1. Its NONSEQ can appear in N+1.
- **Wait states:** `hready_i`=0 freezes `owner`, `dp_owner`, `last` and the counters.
- **Error response:** a two-cycle ERROR response is passed through unchanged.
  - The first cycle has `hready_i`=0, so no handover can occur in it.
- **Locked sequences:** `hmastlock_i`=1 blocks handover regardless of `htrans`.
- **Reset mid-transfer:** the asynchronous reset returns all state immediately. No transfer completion is reported to either master.

## Test plan
- **Parked idle master 0, master 1 requests:**
  - Stimulus: `m1_hbusreq_i`=1 in cycle 5, `hready_i`=1.
  - Required: `hmaster_o`=1 and `m1_hready_o`=1 in cycle 6; `m0_hready_o`=0 in cycle 6; `m1` NONSEQ to 0x0000_1000 appears on `haddr_o` in cycle 6.
- **Contention with `RR_EN`=1:**
  - Stimulus: both masters request continuously, each owner drops `htrans` to IDLE after every transfer.
  - Required: grants alternate 0,1,0,1; after 4 transfers each, `m0_xfer_cnt_o`=4 and `m1_xfer_cnt_o`=4.
- **Fixed priority (`RR_EN`=0):**
  - Stimulus: same traffic as the contention scenario.
  - Required: master 0 wins every handover; `m1_xfer_cnt_o` stays 0 while master 0 keeps requesting.
- **Write handover:**
  - Stimulus: master 0 writes 0xDEAD_BEEF, then goes IDLE; master 1 is requesting; `hready_i`=0 for 2 cycles in the write data phase.
  - Required: `hwdata_o`=0xDEAD_BEEF held through the wait states; handover occurs only on the `hready_i`=1 edge.
- **Lock and error:**
  - Lock: `m0_hmastlock_i`=1 with `m0` IDLE and `m1` requesting → `owner` stays 0 until lock drops.
  - Error: `hresp_i`=1 for 2 cycles → `m0_hresp_o`=1 and `m0_hready_o` = 0 then 1.
- **Counter boundaries:**
  - Saturation: preload the counter to 0xFFFF, issue a further transfer → stays 0xFFFF.
  - Clear priority: `cnt_clr_i`=1 coinciding with an accepted transfer → counter = 0.
  - Reset: `hreset_i` pulsed mid-burst → `hmaster_o`=0 and counters 0 asynchronously.
